// File: rtl/shift_seq_32_if.sv
// Request/response handshake bundle for the sequential shift/rotate unit.
// The producer/consumer side uses master; the unit itself uses slave.
interface shift_seq_32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_err
  );
endinterface

// File: rtl/shift_seq_32.sv
// Multi-cycle 32-bit SLL/SRL/SRA/ROL/ROR unit, moving up to STEP bit positions
// per RUN cycle. Every output comes straight from a flop.
module shift_seq_32 #(
  parameter int unsigned STEP_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  shift_seq_32_if.slave bus
);

  localparam int unsigned STEP  = 1 << STEP_LOG2;
  localparam int unsigned REM_W = 7;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [2:0]         op_q, op_d;
  logic               sign_q, sign_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_result_q, out_result_d;
  logic               out_err_q, out_err_d;

  logic [REM_W-1:0]   s;
  logic [REM_W-1:0]   rem_nxt;
  logic [31:0]        sra_fill;
  logic [31:0]        step_res;

  // One iteration of the datapath: shift/rotate acc by s = min(rem, STEP).
  always_comb begin
    s        = (rem_q > REM_W'(STEP)) ? REM_W'(STEP) : rem_q;
    rem_nxt  = rem_q - s;
    sra_fill = sign_q ? ~(32'hFFFF_FFFF >> s) : 32'h0;
    unique case (op_q)
      OP_SLL:  step_res = acc_q << s;
      OP_SRL:  step_res = acc_q >> s;
      OP_SRA:  step_res = (acc_q >> s) | sra_fill;
      OP_ROL:  step_res = (acc_q << s) | (acc_q >> (REM_W'(32) - s));
      OP_ROR:  step_res = (acc_q >> s) | (acc_q << (REM_W'(32) - s));
      default: step_res = acc_q;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    rem_d        = rem_q;
    op_d         = op_q;
    sign_d       = sign_q;
    err_d        = err_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d      = bus.in_a;
          op_d       = bus.in_op;
          sign_d     = bus.in_a[31];
          err_d      = 1'b0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          unique case (bus.in_op)
            OP_SLL, OP_SRL, OP_SRA:
              rem_d = (|bus.in_b[31:5]) ? REM_W'(32) : REM_W'(bus.in_b[4:0]);
            OP_ROL, OP_ROR:
              rem_d = REM_W'(bus.in_b[4:0]);
            default: begin
              rem_d = '0;
              err_d = 1'b1;
            end
          endcase
        end
      end
      RUN: begin
        acc_d = step_res;
        rem_d = rem_nxt;
        if (rem_nxt == '0) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          out_result_d = step_res;
          out_err_d    = err_q;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      rem_q        <= '0;
      op_q         <= '0;
      sign_q       <= 1'b0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      op_q         <= op_d;
      sign_q       <= sign_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_err    = out_err_q;

endmodule
